// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - sequential command front-end for an 8-bit barrel shifter
module shift_seq #(
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    input  logic             in_rot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [7:0]       sh_a,
    output logic [2:0]       sh_sel,
    output logic             sh_dir,
    input  logic [7:0]       sh_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROT2  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] orig_q, orig_d;
    // Remaining logical distance; never exceeds 8 because larger amounts saturate.
    logic [3:0] rem_q, rem_d;
    // Rotate amount, kept separately so the wrap-around pass knows 8-k.
    logic [2:0] k_q, k_d;
    logic       dir_q, dir_d;
    logic       rot_q, rot_d;

    logic       accept;
    logic       amt_big;
    logic [3:0] amt_eff;
    logic [2:0] step;
    logic [3:0] rem_after;

    assign in_ready = (state_q == IDLE) & rst_n;
    assign busy     = (state_q != IDLE);
    assign accept   = in_valid & in_ready;

    // Any bit at or above weight 8 means the logical shift saturates to a full clear.
    generate
        if (AMT_W > 3) begin : g_big
            assign amt_big = |in_amt[AMT_W-1:3];
        end else begin : g_small
            assign amt_big = 1'b0;
        end
    endgenerate

    // Effective amount: rotates wrap modulo 8, logical shifts clamp at 8.
    always_comb begin
        amt_eff = {1'b0, in_amt[2:0]};
        if (!in_rot && amt_big) begin
            amt_eff = 4'd8;
        end
    end

    // One shifter pass covers at most 7 positions, so 8 splits into 7 then 1.
    assign step      = (rem_q > 4'd7) ? 3'd7 : rem_q[2:0];
    assign rem_after = rem_q - {1'b0, step};

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 8'h00;
            orig_q  <= 8'h00;
            rem_q   <= 4'd0;
            k_q     <= 3'd0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            orig_q  <= orig_d;
            rem_q   <= rem_d;
            k_q     <= k_d;
            dir_q   <= dir_d;
            rot_q   <= rot_d;
        end
    end

    // Next-state logic, shifter drive and result port.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        orig_d    = orig_q;
        rem_d     = rem_q;
        k_d       = k_q;
        dir_d     = dir_q;
        rot_d     = rot_q;
        sh_a      = acc_q;
        sh_sel    = 3'd0;
        sh_dir    = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    orig_d  = in_data;
                    acc_d   = in_data;
                    dir_d   = in_dir;
                    rot_d   = in_rot;
                    rem_d   = amt_eff;
                    k_d     = in_amt[2:0];
                    state_d = (amt_eff == 4'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                sh_a   = acc_q;
                sh_sel = step;
                sh_dir = dir_q;
                acc_d  = sh_out;
                rem_d  = rem_after;
                if (rem_after == 4'd0) begin
                    state_d = rot_q ? ROT2 : DONE;
                end
            end
            ROT2: begin
                // Bits that fell off the first pass re-enter from the other end.
                sh_a    = orig_q;
                sh_sel  = 3'(4'd8 - {1'b0, k_q});
                sh_dir  = ~dir_q;
                acc_d   = acc_q | sh_out;
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = acc_q;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - randomized, model-checked bench for shift_seq
module tb_shift_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [4:0] in_amt = 5'd0;
    logic       in_dir = 1'b0;
    logic       in_rot = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic [7:0] sh_a;
    logic [2:0] sh_sel;
    logic       sh_dir;
    logic [7:0] sh_out;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int hs_cyc = 0;

    // Reference combinational barrel shifter.
    assign sh_out = sh_dir ? (sh_a >> sh_sel) : (sh_a << sh_sel);

    shift_seq #(.AMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_dir(in_dir), .in_rot(in_rot),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sh_a(sh_a), .sh_sel(sh_sel), .sh_dir(sh_dir), .sh_out(sh_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int eff_amt(input int a, input bit rt);
        if (rt) return a % 8;
        return (a >= 8) ? 8 : a;
    endfunction

    function automatic int exp_p(input int a, input bit rt);
        int e;
        e = eff_amt(a, rt);
        if (e == 0) return 0;
        if (!rt && e < 8) return 1;
        return 2;
    endfunction

    function automatic int exp_sel(input int a, input bit rt, input int idx);
        int e;
        e = eff_amt(a, rt);
        if (rt) return (idx == 0) ? e : 8 - e;
        if (e == 8) return (idx == 0) ? 7 : 1;
        return e;
    endfunction

    function automatic int exp_res(input int d, input int a, input bit dr, input bit rt);
        int e;
        e = eff_amt(a, rt);
        if (rt) begin
            if (!dr) return ((d << e) | (d >> (8 - e))) & 255;
            return ((d >> e) | (d << (8 - e))) & 255;
        end
        if (e >= 8) return 0;
        return dr ? (d >> e) : ((d << e) & 255);
    endfunction

    // Transaction-level model: command in flight, cycles until result, and its fields.
    bit m_busy = 0;
    int m_wait = 0;
    int m_d = 0;
    int m_amt = 0;
    bit m_dir = 0;
    bit m_rot = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            m_busy <= 0;
            m_wait <= 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1;
                m_wait <= exp_p(int'(in_amt), in_rot);
                m_d    <= int'(in_data);
                m_amt  <= int'(in_amt);
                m_dir  <= in_dir;
                m_rot  <= in_rot;
            end
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
        end else if (out_ready) begin
            m_busy <= 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int idx;
        if (!rst_n) begin
            chk("rst in_ready", int'(in_ready), 0);
            chk("rst out_valid", int'(out_valid), 0);
            chk("rst busy", int'(busy), 0);
            chk("rst out_data", int'(out_data), 0);
            chk("rst sh_a", int'(sh_a), 0);
            chk("rst sh_sel", int'(sh_sel), 0);
            chk("rst sh_dir", int'(sh_dir), 0);
        end else begin
            chk("in_ready", int'(in_ready), int'(!m_busy));
            chk("busy", int'(busy), int'(m_busy));
            chk("out_valid", int'(out_valid), int'(m_busy && m_wait == 0));
            if (m_busy && m_wait == 0)
                chk("out_data", int'(out_data), exp_res(m_d, m_amt, m_dir, m_rot));
            if (m_busy && m_wait > 0) begin
                idx = exp_p(m_amt, m_rot) - m_wait;
                chk("sh_sel pass", int'(sh_sel), exp_sel(m_amt, m_rot, idx));
                chk("sh_dir pass", int'(sh_dir), (idx == 1 && m_rot) ? int'(!m_dir) : int'(m_dir));
                if (idx == 0 || m_rot)
                    chk("sh_a pass", int'(sh_a), m_d);
            end else begin
                chk("sh_sel idle", int'(sh_sel), 0);
                chk("sh_dir idle", int'(sh_dir), 0);
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [4:0] a, input logic dr, input logic rt);
        bit hs;
        hs = 0;
        in_data = d; in_amt = a; in_dir = dr; in_rot = rt; in_valid = 1'b1;
        for (int i = 0; i < 40 && !hs; i++) begin
            @(negedge clk);
            if (in_ready) begin
                hs = 1;
                hs_cyc = cyc;
            end
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        in_data = 8'($urandom);
        in_amt = 5'($urandom);
        in_dir = 1'($urandom);
        in_rot = 1'($urandom);
        chk("handshake", int'(hs), 1);
    endtask

    task automatic wait_result(input string nm, input int exp_d, input int exp_lat);
        bit got;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1;
                chk({nm, " data"}, int'(out_data), exp_d);
                chk({nm, " latency"}, cyc - hs_cyc - 1, exp_lat);
            end
        end
        if (!got) chk({nm, " timeout"}, 0, 1);
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Hand-computed directed cases.
        send(8'hB5, 5'd3, 1'b0, 1'b0);  wait_result("lsl3", 8'hA8, 1);
        send(8'hFF, 5'd10, 1'b1, 1'b0); wait_result("lsr10", 8'h00, 2);
        send(8'hFF, 5'd31, 1'b1, 1'b0); wait_result("lsr31", 8'h00, 2);
        send(8'h81, 5'd1, 1'b0, 1'b1);  wait_result("rol1", 8'h03, 2);
        send(8'h0F, 5'd11, 1'b1, 1'b1); wait_result("ror11", 8'hE1, 2);
        send(8'h5A, 5'd0, 1'b0, 1'b0);  wait_result("lsl0", 8'h5A, 0);
        send(8'h5A, 5'd8, 1'b0, 1'b1);  wait_result("rol8", 8'h5A, 0);

        // Backpressure with a competing command held valid.
        out_ready = 1'b0;
        send(8'hB5, 5'd3, 1'b0, 1'b0);
        in_data = 8'h81; in_amt = 5'd1; in_dir = 1'b0; in_rot = 1'b1; in_valid = 1'b1;
        repeat (5) @(negedge clk);
        chk("bp out_valid", int'(out_valid), 1);
        chk("bp out_data", int'(out_data), 8'hA8);
        chk("bp in_ready", int'(in_ready), 0);
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        send(8'h81, 5'd1, 1'b0, 1'b1);
        chk("bp second hs cycle", hs_cyc, cyc - 1);
        wait_result("bp second", 8'h03, 2);

        // Reset during the first shift pass.
        send(8'hFF, 5'd10, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", int'(out_valid), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort in_ready", int'(in_ready), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        send(8'hB5, 5'd3, 1'b0, 1'b0);  wait_result("post reset", 8'hA8, 1);

        // Random traffic, backpressure and occasional resets checked by the model.
        for (int i = 0; i < 4000; i++) begin
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            in_amt    = 5'($urandom);
            in_dir    = 1'($urandom);
            in_rot    = 1'($urandom);
            out_ready = ($urandom % 3) != 0;
            rst_n     = ($urandom % 200) != 0;
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
